// File: rtl/md_pkg.sv
// Shared types for the multiply/divide unit: operation codes, FSM states
// and a decode helper. Optional feature macro: MD_MADD_EN (multiply-accumulate).
package md_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5,
    MADD  = 3'd6,
    MADDU = 3'd7
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // True for ops that write hi/lo immediately without entering RUN.
  function automatic logic isMoveOp(input md_op_e op);
    return (op == MTHI) || (op == MTLO);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational result generator for md_unit: maps (op, a, b, hi, lo) to
// the next {hi, lo}. Holds the divide-by-zero and signed-overflow rules.
// Optional feature macro: MD_MADD_EN adds the 2*WIDTH accumulate adder.
module md_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hiN,
  output logic [WIDTH-1:0] loN
);

  logic [2*WIDTH-1:0]       prodS_s;
  logic [2*WIDTH-1:0]       prodU_s;
  logic                     divZero_s;
  logic                     divOvf_s;
  logic signed [WIDTH-1:0]  aS_s;
  logic signed [WIDTH-1:0]  bSafeS_s;
  logic signed [WIDTH-1:0]  quotS_s;
  logic signed [WIDTH-1:0]  remS_s;
  logic [WIDTH-1:0]         bSafeU_s;
  logic [WIDTH-1:0]         quotU_s;
  logic [WIDTH-1:0]         remU_s;

  // Low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
  assign prodS_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prodU_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign divZero_s = (b == {WIDTH{1'b0}});
  assign divOvf_s  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});

  // Corner cases are resolved by the mux below, so the divider only ever
  // sees a safe divisor (never zero, never the overflowing -1).
  assign aS_s     = a;
  assign bSafeS_s = (divZero_s || divOvf_s) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign bSafeU_s = divZero_s ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign quotS_s  = aS_s / bSafeS_s;
  assign remS_s   = aS_s % bSafeS_s;
  assign quotU_s  = a / bSafeU_s;
  assign remU_s   = a % bSafeU_s;

  // Select the next hi/lo for the requested operation; unknown ops keep hi/lo.
  always_comb begin
    hiN = hi;
    loN = lo;
    case (op)
      MULT:  {hiN, loN} = prodS_s;
      MULTU: {hiN, loN} = prodU_s;
      DIV: begin
        if (divZero_s) begin
          hiN = a;
          loN = {WIDTH{1'b1}};
        end else if (divOvf_s) begin
          hiN = {WIDTH{1'b0}};
          loN = a;
        end else begin
          hiN = remS_s;
          loN = quotS_s;
        end
      end
      DIVU: begin
        if (divZero_s) begin
          hiN = a;
          loN = {WIDTH{1'b1}};
        end else begin
          hiN = remU_s;
          loN = quotU_s;
        end
      end
      MTHI:  hiN = a;
      MTLO:  loN = a;
`ifdef MD_MADD_EN
      MADD:  {hiN, loN} = {hi, lo} + prodS_s;
      MADDU: {hiN, loN} = {hi, lo} + prodU_s;
`endif
      default: begin
        hiN = hi;
        loN = lo;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage. Long ops latch their result at issue,
// hold busy for the op latency and commit to HI/LO on the last busy edge;
// flush cancels without commit. Optional feature macro: MD_MADD_EN.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  md_op_e           op_s;
  md_state_e        state_r;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    lat_s;
  logic             isLong_s;
  logic             busy_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] resHi_r;
  logic [WIDTH-1:0] resLo_r;
  logic [WIDTH-1:0] calcHi_s;
  logic [WIDTH-1:0] calcLo_s;

  assign op_s = md_op_e'(md_op);

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op  (op_s),
    .a   (a),
    .b   (b),
    .hi  (hi_r),
    .lo  (lo_r),
    .hiN (calcHi_s),
    .loN (calcLo_s)
  );

  // Classify the issued op and pick its busy latency (zero for non-long ops).
  always_comb begin
    isLong_s = 1'b0;
    lat_s    = {CW{1'b0}};
    case (op_s)
      MULT, MULTU: begin
        isLong_s = 1'b1;
        lat_s    = CW'(MUL_LAT);
      end
      DIV, DIVU: begin
        isLong_s = 1'b1;
        lat_s    = CW'(DIV_LAT);
      end
`ifdef MD_MADD_EN
      MADD, MADDU: begin
        isLong_s = 1'b1;
        lat_s    = CW'(MUL_LAT);
      end
`endif
      default: begin
        isLong_s = 1'b0;
        lat_s    = {CW{1'b0}};
      end
    endcase
  end

  // FSM, latency counter, latched result and the HI/LO/busy output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      resHi_r <= {WIDTH{1'b0}};
      resLo_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          // A flush in the same cycle suppresses the issue entirely.
          if (start && !flush) begin
            if (isLong_s) begin
              resHi_r <= calcHi_s;
              resLo_r <= calcLo_s;
              cnt_r   <= lat_s;
              busy_r  <= 1'b1;
              state_r <= RUN;
            end else if (isMoveOp(op_s)) begin
              hi_r <= calcHi_s;
              lo_r <= calcLo_s;
            end
          end
        end
        RUN: begin
          // Flush wins over the final-cycle commit; start is ignored here.
          if (flush) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (cnt_r == CW'(1)) begin
            hi_r    <= resHi_r;
            lo_r    <= resLo_r;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases followed by random
// ops, all compared against a 64-bit arithmetic reference model of HI/LO.
module tb_md_unit;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [2:0]  mdOp;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int nTests = 0;
  int nFail  = 0;

  logic [31:0] mHi;
  logic [31:0] mLo;

  md_unit #(.WIDTH(32), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (mdOp),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: returns busy latency (0 = immediate/no-op) and the next hi/lo.
  function automatic int refOp(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                               input logic [31:0] hv, input logic [31:0] lv,
                               output logic [31:0] nh, output logic [31:0] nl);
    longint          sp;
    longint unsigned up;
    int              sa, sb, q;
    int unsigned     ua, ub;
    nh = hv; nl = lv;
    sa = av; sb = bv; ua = av; ub = bv;
    sp = sa; sp = sp * sb;
    up = ua; up = up * ub;
    case (op)
      3'd0: begin {nh, nl} = sp; return MUL_LAT; end
      3'd1: begin {nh, nl} = up; return MUL_LAT; end
      3'd2: begin
        if (bv == 32'd0) begin nl = 32'hFFFF_FFFF; nh = av; end
        else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin nl = av; nh = 32'd0; end
        else begin q = sa / sb; nl = q; nh = sa - q * sb; end
        return DIV_LAT;
      end
      3'd3: begin
        if (bv == 32'd0) begin nl = 32'hFFFF_FFFF; nh = av; end
        else begin nl = ua / ub; nh = ua - (ua / ub) * ub; end
        return DIV_LAT;
      end
      3'd4: begin nh = av; return 0; end
      3'd5: begin nl = av; return 0; end
`ifdef MD_MADD_EN
      3'd6: begin {nh, nl} = {hv, lv} + sp; return MUL_LAT; end
      3'd7: begin {nh, nl} = {hv, lv} + up; return MUL_LAT; end
`endif
      default: return 0;
    endcase
  endfunction

  // Issue one op, track busy cycle by cycle, optionally flush at busy cycle
  // flushAt or inject a stray start at busy cycle 2, then check hi/lo.
  task automatic runOp(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input int flushAt, input bit intrude, input string tag);
    logic [31:0] nh, nl;
    int          lat;
    bit          flushed;
    lat = refOp(op, av, bv, mHi, mLo, nh, nl);
    @(negedge clk);
    start = 1'b1; mdOp = op; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    if (lat == 0) begin
      mHi = nh; mLo = nl;
      chk({tag, "_busy"}, busy, 1'b0);
    end else begin
      flushed = 1'b0;
      for (int k = 1; k <= lat && !flushed; k++) begin
        chk({tag, "_busy_hi"}, busy, 1'b1);
        if (k == 1) chk({tag, "_hold_hi"}, hi, mHi);
        if (intrude && k == 2) begin start = 1'b1; mdOp = 3'd4; a = 32'hDEAD_BEEF; end
        if (k == flushAt) begin flush = 1'b1; flushed = 1'b1; end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
      end
      if (!flushed) begin mHi = nh; mLo = nl; end
      chk({tag, "_busy_end"}, busy, 1'b0);
    end
    chk({tag, "_hi"}, hi, mHi);
    chk({tag, "_lo"}, lo, mLo);
  endtask

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0; mdOp = 3'd0; a = 32'd0; b = 32'd0;
    mHi = 32'd0; mLo = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    runOp(3'd0, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, "mult");
    chk("mult_hi_const", hi, 32'hFFFF_FFFF);
    runOp(3'd1, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, "multu");
    chk("multu_hi_const", hi, 32'h0000_0001);
    runOp(3'd3, 32'd7, 32'd2, 0, 1'b1, "divu_stray");
    chk("divu_lo_const", lo, 32'd3);
    runOp(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, "div_neg");
    chk("div_neg_lo_const", lo, 32'hFFFF_FFFD);
    runOp(3'd2, 32'd5, 32'd0, 0, 1'b0, "div_zero");
    runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "div_ovf");
    runOp(3'd4, 32'h0000_00AA, 32'd0, 0, 1'b0, "mthi");
    runOp(3'd2, 32'd100, 32'd7, 4, 1'b0, "div_flush");
    chk("flush_hi_const", hi, 32'h0000_00AA);
    runOp(3'd0, 32'd3, 32'd4, MUL_LAT, 1'b0, "flush_last");

    // start together with flush in IDLE must be ignored
    @(negedge clk);
    start = 1'b1; flush = 1'b1; mdOp = 3'd4; a = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_busy", busy, 1'b0);
    chk("idle_flush_hi", hi, mHi);

`ifdef MD_MADD_EN
    runOp(3'd4, 32'd0, 32'd0, 0, 1'b0, "madd_prehi");
    runOp(3'd5, 32'hFFFF_FFFF, 32'd0, 0, 1'b0, "madd_prelo");
    runOp(3'd7, 32'd1, 32'd1, 0, 1'b0, "maddu");
    chk("maddu_hi_const", hi, 32'd1);
`endif

    // asynchronous reset in the middle of a long op
    runOp(3'd5, 32'h0000_0077, 32'd0, 0, 1'b0, "pre_rst");
    @(negedge clk);
    start = 1'b1; a = 32'd1; b = 32'd1;
`ifdef MD_MADD_EN
    mdOp = 3'd7;
`else
    mdOp = 3'd2;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    mHi = 32'd0; mLo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("postrst_busy", busy, 1'b0);

    for (int i = 0; i < 60; i++) begin
      runOp(3'($urandom_range(0, 7)), pickVal(), pickVal(),
            ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, DIV_LAT)) : 0,
            1'($urandom_range(0, 1)), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit for the E stage of the pipelined core. It executes signed and unsigned multiply and divide with configurable latencies and writes results into its private HI/LO registers. It holds `busy` while an operation is in flight, and the hazard unit stalls on that signal. New relative to the previous unit:
- operand width and per-operation latency are parameters;
- an in-flight operation can be cancelled with a flush;
- divide-by-zero and overflow results are defined;
- multiply-accumulate is available as a compile-time option.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width.
- `MUL_LAT`, 5, busy cycles for multiply and multiply-accumulate ops; must be at least 1.
- `DIV_LAT`, 10, busy cycles for divide ops; must be at least 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue strobe; `md_op`, `a` and `b` are sampled when it is high.
- `md_op`  in  3  operation code (`md_pkg::md_op_e`).
- `a`  in  WIDTH  forwarded rs value.
- `b`  in  WIDTH  forwarded rt value.
- `flush`  in  1  cancels the in-flight operation (exception or branch squash).
- `busy`  out  1  an operation is in flight.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
Ops:
- MULT, MULTU: {hi,lo} = a*b, as a 2·WIDTH-bit product, signed or unsigned.
- DIV, DIVU: lo = quotient, hi = remainder. Quotient truncates toward zero; the remainder takes the sign of the dividend.
- MTHI, MTLO: write `a` into hi or lo.
- MADD, MADDU: {hi,lo} += a*b. Only exists when the configuration macro is defined (see Configuration).

Defined corner cases:
- Divide by zero: lo = all ones; hi = a.
- Signed overflow (most-negative value ÷ −1): lo = a; hi = 0.

State machine, two states:
- IDLE: `start` with a multiply or divide op latches the result, loads the counter with the op's latency, and moves to RUN. `start` with MTHI or MTLO writes the register at that edge and stays in IDLE.
- RUN: the counter decrements each cycle. When it reaches 1, the latched result is committed to hi/lo and the state returns to IDLE.

Boundary rules:
- `start` in RUN is ignored. The hazard unit guarantees it never happens; the bench checks it has no effect.
- `flush` in RUN goes to IDLE at the next edge with hi/lo unchanged, including when the counter is 1 (flush beats commit).
- `start` and `flush` together in IDLE: start is ignored.
- MADD in flight: the accumulate base is the hi/lo value sampled at start.
- Undefined `md_op` with `start`: no-op.
- Reset mid-operation: immediate return to IDLE; hi, lo and busy go to 0.

## Timing
Reset values:
- `busy` = 0, `hi` = 0, `lo` = 0, state = IDLE.

Multiply/divide op:
- `start` at edge N. `busy` is high for cycles N+1 … N+LAT.
- hi/lo take the new value at edge N+LAT, in the same edge that `busy` falls.

MTHI/MTLO:
- Register visible one cycle after the `start` edge; `busy` never rises.

Latencies:
- Multiply, MADD: `MUL_LAT` busy cycles.
- Divide: `DIV_LAT` busy cycles.

Hazard interface:
- The hazard unit stalls any instruction that reads hi/lo (mfhi/mflo) or is itself a multiply/divide-unit op while `busy` is high, and also during the cycle in which `start` is high.
- `busy` is registered, never combinational from `start`.

Arithmetic and widths:
- Intermediate width 2·WIDTH for products and accumulates; accumulate wraps modulo 2^(2·WIDTH).
- Counter width is $clog2(max(MUL_LAT,DIV_LAT)+1).

## Configuration
`MD_MADD_EN`:
- Defined: MADD and MADDU are decoded, with a 2·WIDTH adder on the product path.
- Undefined: both codes are treated as undefined ops (no-op), and the adder is absent.

## Structure
- Package `md_pkg` holds:
  - the `md_op_e` enum: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MADD=6, MADDU=7;
  - the state enum `md_state_e` (IDLE, RUN).
- Sub-module `md_calc`: purely combinational result generator, taking (op, a, b, hi, lo) to {hi_n, lo_n}. It contains the divide corner-case handling.
- The FSM, counter and HI/LO registers live in `md_unit`.

## Test plan
- MULT a=0xFFFFFFFF, b=2 → busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIVU a=7, b=2 → busy for 10 cycles, lo=3, hi=1. DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=5, b=0 → lo=0xFFFFFFFF, hi=5. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload hi=0xAA via MTHI (no busy, visible next cycle). DIV, then flush at busy cycle 4 → busy falls next edge; hi stays 0xAA. A second `start` issued mid-RUN is ignored.
- With `MD_MADD_EN`: hi=0, lo=0xFFFFFFFF, then MADDU a=1, b=1 → hi=1, lo=0. Assert reset (low) during this op → hi=lo=0 and busy=0 immediately.
